risc_controller: RTL

// - Sequences the 8-bit RISC CPU through its fixed 8-phase fetch/execute cycle.
// - Drives the control strobes for the instruction register, PC, accumulator,

---
 rtl/risc_controller.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/risc_controller.sv
// Phase sequencer and control-strobe decoder for the 8-bit RISC CPU.
// Optional macro SINGLE_STEP_EN adds a step input and a WAIT state after Ph7.
module risc_controller #(
  parameter int OP_CODE_WIDTH = 3,
  parameter int PHASE_WIDTH   = 3
) (
  input  logic                     clk,
  input  logic                     n_rst,
`ifdef SINGLE_STEP_EN
  input  logic                     step,
`endif
  input  logic [OP_CODE_WIDTH-1:0] op_code,
  input  logic                     zero,
  output logic                     sel,
  output logic                     rd,
  output logic                     ld_ir,
  output logic                     inc_pc,
  output logic                     ld_pc,
  output logic                     ld_ac,
  output logic                     wr,
  output logic                     data_e,
  output logic                     halt,
  output logic [PHASE_WIDTH-1:0]   phase
);

  typedef enum logic [PHASE_WIDTH-1:0] {
    INST_ADDR  = PHASE_WIDTH'(0),
    INST_FETCH = PHASE_WIDTH'(1),
    INST_LOAD  = PHASE_WIDTH'(2),
    IDLE       = PHASE_WIDTH'(3),
    OP_ADDR    = PHASE_WIDTH'(4),
    OP_FETCH   = PHASE_WIDTH'(5),
    ALU_OP     = PHASE_WIDTH'(6),
    STORE      = PHASE_WIDTH'(7)
  } phase_e;

  localparam logic [OP_CODE_WIDTH-1:0] OP_HLT = OP_CODE_WIDTH'(0);
  localparam logic [OP_CODE_WIDTH-1:0] OP_SKZ = OP_CODE_WIDTH'(1);
  localparam logic [OP_CODE_WIDTH-1:0] OP_ADD = OP_CODE_WIDTH'(2);
  localparam logic [OP_CODE_WIDTH-1:0] OP_AND = OP_CODE_WIDTH'(3);
  localparam logic [OP_CODE_WIDTH-1:0] OP_XOR = OP_CODE_WIDTH'(4);
  localparam logic [OP_CODE_WIDTH-1:0] OP_LDA = OP_CODE_WIDTH'(5);
  localparam logic [OP_CODE_WIDTH-1:0] OP_STO = OP_CODE_WIDTH'(6);
  localparam logic [OP_CODE_WIDTH-1:0] OP_JMP = OP_CODE_WIDTH'(7);

  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;
  logic   wait_q;
  logic   blank;
  logic   is_hlt, is_sto, is_jmp, is_skz, aluop;

`ifdef SINGLE_STEP_EN
  logic wait_d;
`endif

  assign is_hlt = (op_code == OP_HLT);
  assign is_sto = (op_code == OP_STO);
  assign is_jmp = (op_code == OP_JMP);
  assign is_skz = (op_code == OP_SKZ);
  assign aluop  = (op_code == OP_ADD) || (op_code == OP_AND) ||
                  (op_code == OP_XOR) || (op_code == OP_LDA);

  always_comb begin
    phase_d  = phase_e'(phase_q + 1'b1);
    halted_d = halted_q;
`ifdef SINGLE_STEP_EN
    wait_d   = wait_q;
`endif
    if (halted_q) begin
      phase_d = phase_q;
`ifdef SINGLE_STEP_EN
    end else if (wait_q) begin
      phase_d = step ? INST_ADDR : phase_q;
      wait_d  = !step;
    end else if (phase_q == STORE) begin
      phase_d = STORE;
      wait_d  = 1'b1;
`endif
    end else if (phase_q == OP_ADDR && is_hlt) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

`ifdef SINGLE_STEP_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) wait_q <= 1'b0;
    else        wait_q <= wait_d;
  end
`else
  assign wait_q = 1'b0;
`endif

  // Halted or waiting: every strobe is silenced, only halt may show.
  assign blank = halted_q | wait_q;
  assign phase = phase_q;

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = halted_q;
    if (!blank) begin
      unique case (phase_q)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = is_hlt;
        end
        OP_FETCH: begin
          rd = aluop;
        end
        ALU_OP: begin
          rd     = aluop;
          inc_pc = is_skz & zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
      endcase
    end
  end

endmodule
